// File: rtl/axi_write_master.sv
`timescale 1ns/1ps
// AXI4 write master: drains an AXI4-Stream into memory as INCR bursts.
// The W channel is a combinational pass-through of the stream and is gated so
// that it only carries beats of bursts whose address has been accepted.
//
// state | meaning
// IDLE  | waiting for ctrl_start
// BUSY  | issuing AW, passing W beats, collecting B responses
// DONE  | one-cycle ctrl_done pulse
module axi_write_master #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 32,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_BURST_LEN       = 16,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
  output logic                      ctrl_done,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata
);

  localparam int BB        = C_DATA_WIDTH / 8;
  localparam int BURST_LOG = $clog2(C_BURST_LEN);
  localparam int OUT_W     = $clog2(C_MAX_OUTSTANDING + 1);

  localparam logic [C_ADDR_WIDTH-1:0]   BURST_STEP = C_ADDR_WIDTH'(C_BURST_LEN * BB);
  localparam logic [C_LENGTH_WIDTH-1:0] BEAT_MASK  = C_LENGTH_WIDTH'(C_BURST_LEN - 1);
  localparam logic [OUT_W-1:0]          OUT_MAX    = OUT_W'(C_MAX_OUTSTANDING);
  localparam logic [7:0]                FULL_AWLEN = 8'(C_BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nx;

  logic [C_LENGTH_WIDTH-1:0] len_q;
  logic [C_LENGTH_WIDTH-1:0] rem_q;
  logic [C_LENGTH_WIDTH-1:0] n_bursts_q;
  logic [C_LENGTH_WIDTH-1:0] aw_cnt;
  logic [C_LENGTH_WIDTH-1:0] w_burst;
  logic [C_LENGTH_WIDTH-1:0] beat_cnt;
  logic [OUT_W-1:0]          outstanding;
  logic                      awvalid_q;
  logic [C_ADDR_WIDTH-1:0]   awaddr_q;
  logic [7:0]                awlen_q;

  logic                      start_go;
  logic [C_LENGTH_WIDTH-1:0] start_rem;
  logic [C_LENGTH_WIDTH-1:0] start_bursts;
  logic [7:0]                start_awlen;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      b_hs;
  logic                      b_dec;
  logic                      w_allowed;
  logic [C_LENGTH_WIDTH-1:0] beat_next;
  logic [C_LENGTH_WIDTH-1:0] aw_cnt_nx;
  logic [OUT_W-1:0]          out_nx;
  logic [7:0]                next_awlen;
  logic                      all_done;

  // Handshakes, burst bookkeeping and W-channel gating.
  always_comb begin
    start_go     = (state == IDLE) && ctrl_start;
    start_rem    = ctrl_length & BEAT_MASK;
    start_bursts = (ctrl_length >> BURST_LOG) + C_LENGTH_WIDTH'(start_rem != '0);
    start_awlen  = ((start_bursts == C_LENGTH_WIDTH'(1)) && (start_rem != '0))
                   ? 8'(start_rem - 1'b1) : FULL_AWLEN;

    m_axi_bready = (state == BUSY);
    b_hs         = m_axi_bready && m_axi_bvalid;
    b_dec        = b_hs && (outstanding != '0);
    aw_hs        = awvalid_q && m_axi_awready;

    // A beat may only leave once the AW of its burst has been accepted.
    w_allowed     = (state == BUSY) && (w_burst < aw_cnt);
    m_axi_wvalid  = s_axis_tvalid && w_allowed;
    s_axis_tready = m_axi_wready && w_allowed;
    w_hs          = m_axi_wvalid && m_axi_wready;

    beat_next   = beat_cnt + 1'b1;
    m_axi_wlast = ((beat_next & BEAT_MASK) == '0) || (beat_next == len_q);

    aw_cnt_nx = aw_cnt + C_LENGTH_WIDTH'(aw_hs);
    out_nx    = outstanding;
    if (aw_hs && !b_dec) out_nx = outstanding + 1'b1;
    else if (!aw_hs && b_dec) out_nx = outstanding - 1'b1;

    next_awlen = ((aw_cnt_nx == n_bursts_q - 1'b1) && (rem_q != '0))
                 ? 8'(rem_q - 1'b1) : FULL_AWLEN;

    // Counts the B arriving this cycle so ctrl_done follows the last B directly.
    all_done = (aw_cnt == n_bursts_q) && (w_burst == n_bursts_q) && (out_nx == '0);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (ctrl_start) state_nx = (ctrl_length == '0) ? DONE : BUSY;
      BUSY: if (all_done) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Transfer parameters, AW issue, outstanding and W beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      rem_q       <= '0;
      n_bursts_q  <= '0;
      aw_cnt      <= '0;
      w_burst     <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
    end else if (start_go) begin
      len_q       <= ctrl_length;
      rem_q       <= start_rem;
      n_bursts_q  <= start_bursts;
      aw_cnt      <= '0;
      w_burst     <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
      awvalid_q   <= (ctrl_length != '0);
      awaddr_q    <= ctrl_addr_offset;
      awlen_q     <= start_awlen;
    end else if (state == BUSY) begin
      aw_cnt      <= aw_cnt_nx;
      outstanding <= out_nx;
      // awvalid only drops after a handshake, so AW stays stable while stalled.
      awvalid_q   <= (aw_cnt_nx < n_bursts_q) && (out_nx < OUT_MAX);
      if (aw_hs) begin
        awaddr_q <= awaddr_q + BURST_STEP;
        awlen_q  <= next_awlen;
      end
      if (w_hs) begin
        beat_cnt <= beat_next;
        if (m_axi_wlast) w_burst <= w_burst + 1'b1;
      end
    end else begin
      awvalid_q <= 1'b0;
    end
  end

  assign ctrl_done     = (state == DONE);
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;

endmodule

// File: tb/tb_axi_write_master.sv
`timescale 1ns/1ps
// Randomized bench for axi_write_master with a transaction-level memory-side model.
module tb_axi_write_master;

  localparam int AW   = 64;
  localparam int DW   = 32;
  localparam int LW   = 32;
  localparam int BL   = 16;
  localparam int MAXO = 2;
  localparam logic [63:0] STEP = 64'(BL * DW / 8);

  logic          clk;
  logic          rst_n;
  logic          ctrl_start;
  logic [AW-1:0] ctrl_addr_offset;
  logic [LW-1:0] ctrl_length;
  logic          ctrl_done;
  logic          m_axi_awvalid, m_axi_awready;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic          m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_bvalid, m_axi_bready;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] s_axis_tdata;

  axi_write_master #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_LENGTH_WIDTH(LW),
    .C_BURST_LEN(BL), .C_MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_start(ctrl_start), .ctrl_addr_offset(ctrl_addr_offset),
    .ctrl_length(ctrl_length), .ctrl_done(ctrl_done),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // stimulus knobs: percent chance each cycle
  int aw_p = 100, w_p = 100, t_p = 100, b_p = 100, b_delay = 2;
  bit b_hold = 1'b0;

  // reference model of the transfer, advanced only from observed handshakes
  logic [DW-1:0] src[$];
  int            b_due[$];
  int            cyc = 0;
  bit            m_busy = 1'b0;
  int            start_cyc = 0;
  int            m_len = 0;
  logic [63:0]   m_base = '0;
  int            n_exp = 0;
  int            aw_cnt = 0, beats = 0, b_cnt = 0, outst = 0, done_cnt = 0;
  bit            prev_stall = 1'b0;
  logic [63:0]   prev_addr = '0;
  logic [7:0]    prev_len = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic monitor_cycle();
    bit complete, in_busy, allowed, accept;
    logic [63:0] exp_addr;
    logic [7:0]  exp_len;
    bit          exp_last;
    complete = (aw_cnt == n_exp) && (beats == m_len) && (outst == 0);
    in_busy  = m_busy && (cyc > start_cyc);
    accept   = ctrl_start && !m_busy;
    chk("done", ctrl_done, in_busy && complete);
    chk("bready", m_axi_bready, in_busy && !complete);
    allowed = in_busy && (beats < m_len) && ((beats / BL) < aw_cnt);
    chk("wvalid_gate", m_axi_wvalid, s_axis_tvalid && allowed);
    chk("tready_gate", s_axis_tready, m_axi_wready && allowed);
    if (m_busy && cyc == start_cyc + 1 && m_len != 0) chk("aw_latency", m_axi_awvalid, 1);
    if (outst >= MAXO) chk("aw_at_max", m_axi_awvalid, 0);
    if (aw_cnt == n_exp) chk("aw_extra", m_axi_awvalid, 0);
    if (prev_stall) begin
      chk("aw_hold_valid", m_axi_awvalid, 1);
      chk("aw_hold_addr", m_axi_awaddr, prev_addr);
      chk("aw_hold_len", m_axi_awlen, 64'(prev_len));
    end
    prev_stall = m_axi_awvalid && !m_axi_awready;
    prev_addr  = m_axi_awaddr;
    prev_len   = m_axi_awlen;
    if (m_axi_awvalid && m_axi_awready) begin
      exp_addr = m_base + 64'(aw_cnt) * STEP;
      exp_len  = (aw_cnt == n_exp - 1 && (m_len % BL) != 0) ? 8'((m_len % BL) - 1) : 8'(BL - 1);
      chk("aw_addr", m_axi_awaddr, exp_addr);
      chk("aw_len", 64'(m_axi_awlen), 64'(exp_len));
      aw_cnt++;
      outst++;
    end
    if (m_axi_wvalid && m_axi_wready && beats < m_len) begin
      exp_last = ((beats + 1) % BL == 0) || (beats + 1 == m_len);
      chk("wdata", m_axi_wdata, (beats < src.size()) ? src[beats] : 'x);
      chk("wlast", m_axi_wlast, exp_last);
      chk("wstrb", m_axi_wstrb, 4'hF);
      if (exp_last) b_due.push_back(cyc + b_delay);
      beats++;
    end
    if (m_axi_bvalid && m_axi_bready) begin
      b_cnt++;
      outst--;
      if (b_due.size() > 0) void'(b_due.pop_front());
    end
    if (in_busy && complete) begin
      m_busy = 1'b0;
      done_cnt++;
    end
    if (accept) begin
      m_busy = 1'b1; start_cyc = cyc;
      m_len = int'(ctrl_length); m_base = ctrl_addr_offset;
      n_exp = (m_len + BL - 1) / BL;
      aw_cnt = 0; beats = 0; b_cnt = 0; outst = 0;
      b_due.delete();
    end
  endtask

  task automatic model_clear();
    m_busy = 1'b0; m_len = 0; n_exp = 0;
    aw_cnt = 0; beats = 0; b_cnt = 0; outst = 0;
    prev_stall = 1'b0;
    b_due.delete();
  endtask

  task automatic start_xfer(input logic [63:0] base, input int len);
    src.delete();
    for (int i = 0; i < len; i++) src.push_back($urandom);
    @(posedge clk); #2;
    ctrl_addr_offset = base;
    ctrl_length      = LW'(len);
    ctrl_start       = 1'b1;
    @(posedge clk); #2;
    ctrl_start = 1'b0;
  endtask

  task automatic pulse_start_busy(input int len);
    @(posedge clk); #2;
    ctrl_addr_offset = 64'hDEAD_0000;
    ctrl_length      = LW'(len);
    ctrl_start       = 1'b1;
    @(posedge clk); #2;
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    int d0;
    d0 = done_cnt;
    i = 0;
    while (m_busy && i < limit) begin
      @(posedge clk);
      i++;
    end
    chk("done_timeout", m_busy, 0);
    repeat (3) @(posedge clk);
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    rst_n = 1'b0; ctrl_start = 1'b0; ctrl_addr_offset = '0; ctrl_length = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0;

    fork
      forever begin
        @(posedge clk); #1;
        m_axi_awready = roll(aw_p);
        m_axi_wready  = roll(w_p);
        s_axis_tvalid = roll(t_p);
        s_axis_tdata  = (beats < src.size()) ? src[beats] : $urandom;
        m_axi_bvalid  = !b_hold && (b_due.size() > 0) && (cyc >= b_due[0]) && roll(b_p);
      end
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) model_clear();
        else monitor_cycle();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_done", ctrl_done, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_tready", s_axis_tready, 0);
    @(posedge clk); #3 rst_n = 1'b1;

    // T1: full throughput, 40 beats, start pulsed again while busy
    start_xfer(64'h1000, 40);
    repeat (15) @(posedge clk);
    pulse_start_busy(5);
    wait_done(2000);

    // T2: zero length
    start_xfer(64'h2000, 0);
    wait_done(20);

    // T3: B withheld, outstanding limit reached
    b_hold = 1'b1;
    start_xfer(64'h0, 64);
    repeat (60) @(posedge clk);
    #1;
    chk("t3_aw_stalled", aw_cnt, MAXO);
    chk("t3_awvalid_low", m_axi_awvalid, 0);
    b_hold = 1'b0;
    wait_done(2000);

    // T4: AW stalled for 10 cycles while the stream is valid
    aw_p = 0;
    start_xfer(64'h4000, 20);
    repeat (10) @(posedge clk);
    aw_p = 100;
    wait_done(2000);

    // T5: random stalls, including an address that wraps
    aw_p = 60; w_p = 70; t_p = 65; b_p = 50; b_delay = 1;
    start_xfer(64'h0000_0001_0000_0000, 100);
    wait_done(5000);
    start_xfer(64'hFFFF_FFFF_FFFF_FFC0, 40);
    wait_done(5000);
    for (int k = 0; k < 6; k++) begin
      aw_p = 30 + int'($urandom_range(70));
      w_p  = 30 + int'($urandom_range(70));
      t_p  = 30 + int'($urandom_range(70));
      b_p  = 30 + int'($urandom_range(70));
      start_xfer({32'($urandom), 32'($urandom)} & ~64'h3F, int'($urandom_range(70)));
      wait_done(5000);
    end

    // T6: reset mid-transfer, then a clean 16-beat transfer
    aw_p = 80; w_p = 80; t_p = 80; b_p = 80;
    start_xfer(64'h8000, 100);
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_awvalid", m_axi_awvalid, 0);
    chk("t6_wvalid", m_axi_wvalid, 0);
    chk("t6_tready", s_axis_tready, 0);
    chk("t6_bready", m_axi_bready, 0);
    chk("t6_done", ctrl_done, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    aw_p = 100; w_p = 100; t_p = 100; b_p = 100; b_delay = 2;
    start_xfer(64'h9000, 16);
    wait_done(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
